// File: rtl/scanline_buf_ctrl_if.sv
// Bus between the PPU pixel writer / VGA timing generator (master) and the
// ping-pong scanline buffer controller (slave).
interface scanline_buf_ctrl_if;
    logic       ppu_pix_valid;
    logic [7:0] ppu_pix_x;
    logic [5:0] ppu_pix_data;
    logic       ppu_line_done;
    logic       flush;
    logic [7:0] vga_addr;
    logic       vga_line_end;
    logic [5:0] vga_pixel;
    logic       disp_valid;
    logic [7:0] underrun_cnt;
    logic       overrun;

    modport master (
        output ppu_pix_valid, ppu_pix_x, ppu_pix_data, ppu_line_done,
               flush, vga_addr, vga_line_end,
        input  vga_pixel, disp_valid, underrun_cnt, overrun
    );

    modport slave (
        input  ppu_pix_valid, ppu_pix_x, ppu_pix_data, ppu_line_done,
               flush, vga_addr, vga_line_end,
        output vga_pixel, disp_valid, underrun_cnt, overrun
    );
endinterface

// File: rtl/scanline_buf_ctrl.sv
// Ping-pong scanline buffer: PPU fills one 256x6 bank while VGA reads the other,
// each line shown REPEAT times. Define LINEBUF_STATS_EN to build underrun/overrun stats.
module scanline_buf_ctrl #(
    parameter int unsigned REPEAT      = 2,
    parameter int unsigned LINE_LEN    = 256,
    parameter logic [5:0]  BLANK_COLOR = 6'h0F
) (
    input  logic               clk,
    input  logic               rst_n,
    scanline_buf_ctrl_if.slave lb_io
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [1:0] REP_LAST = 2'(REPEAT - 1);

    state_t     state_q;
    logic       wr_bank_q;
    logic       disp_bank_q;
    logic       first_line_q;
    logic       disp_valid_q;
    logic       show_q;
    logic [1:0] rep_cnt_q;
    logic [5:0] mem_q [0:511];
    logic [5:0] rd_data_q;

    logic line_end;
    logic line_done;
    logic swap_pt;
    logic wr_en;

    assign line_end  = lb_io.vga_line_end;
    assign line_done = lb_io.ppu_line_done;
    // A freshly filled first line is shown at the very next line boundary.
    assign swap_pt   = line_end &&
                       ((rep_cnt_q == REP_LAST) || (state_q == PENDING && first_line_q));
    assign wr_en     = lb_io.ppu_pix_valid && (state_q != PENDING) &&
                       (32'(lb_io.ppu_pix_x) < LINE_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            wr_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b1;
            rep_cnt_q    <= 2'd0;
            first_line_q <= 1'b0;
            disp_valid_q <= 1'b0;
        end else if (lb_io.flush) begin
            state_q      <= EMPTY;
            rep_cnt_q    <= 2'd0;
            first_line_q <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (line_end) begin
                        rep_cnt_q <= (rep_cnt_q == REP_LAST) ? 2'd0 : rep_cnt_q + 2'd1;
                    end
                    if (line_done) begin
                        state_q      <= PENDING;
                        first_line_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (swap_pt) begin
                        disp_bank_q  <= wr_bank_q;
                        wr_bank_q    <= ~wr_bank_q;
                        rep_cnt_q    <= 2'd0;
                        disp_valid_q <= 1'b1;
                        first_line_q <= 1'b0;
                        state_q      <= SHOW;
                    end else if (line_end) begin
                        rep_cnt_q <= rep_cnt_q + 2'd1;
                    end
                end
                SHOW: begin
                    if (swap_pt) begin
                        // Without a completed line the current bank is simply redisplayed.
                        rep_cnt_q <= 2'd0;
                        if (line_done) begin
                            disp_bank_q <= wr_bank_q;
                            wr_bank_q   <= ~wr_bank_q;
                        end
                    end else begin
                        if (line_end) begin
                            rep_cnt_q <= rep_cnt_q + 2'd1;
                        end
                        if (line_done) begin
                            state_q <= PENDING;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef LINEBUF_STATS_EN
    logic [7:0] underrun_cnt_q;
    logic       overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_q <= 8'd0;
            overrun_q      <= 1'b0;
        end else if (!lb_io.flush) begin
            if (state_q == SHOW && swap_pt && !line_done && underrun_cnt_q != 8'hFF) begin
                underrun_cnt_q <= underrun_cnt_q + 8'd1;
            end
            if (state_q == PENDING && line_done) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign lb_io.underrun_cnt = underrun_cnt_q;
    assign lb_io.overrun      = overrun_q;
`else
    assign lb_io.underrun_cnt = 8'd0;
    assign lb_io.overrun      = 1'b0;
`endif

    // Line banks: bank select is the MSB of the 9-bit address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, lb_io.ppu_pix_x}] <= lb_io.ppu_pix_data;
        end
        rd_data_q <= mem_q[{disp_bank_q, lb_io.vga_addr}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_q <= 1'b0;
        end else begin
            show_q <= disp_valid_q && !lb_io.flush;
        end
    end

    assign lb_io.vga_pixel  = show_q ? rd_data_q : BLANK_COLOR;
    assign lb_io.disp_valid = disp_valid_q;

endmodule

// File: tb/tb_scanline_buf_ctrl.sv
// Directed bench for scanline_buf_ctrl (REPEAT=2): pixel scoreboard plus status checks.
module tb_scanline_buf_ctrl;

    localparam logic [5:0] BLANK = 6'h0F;
`ifdef LINEBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_show = -1;
    int   exp_under = 0;
    int   exp_over = 0;
    logic [5:0] sb_q[$];

    always #5 clk = ~clk;

    scanline_buf_ctrl_if bus ();

    scanline_buf_ctrl #(.REPEAT(2), .LINE_LEN(256), .BLANK_COLOR(6'h0F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb_io (bus)
    );

    function automatic logic [5:0] pix(input int id, input logic [7:0] a);
        logic [5:0] k;
        case (id)
            1:       k = 6'h30;
            2:       k = 6'h15;
            3:       k = 6'h2A;
            4:       k = 6'h07;
            default: k = 6'h00;
        endcase
        return a[5:0] ^ k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".underrun_cnt"}, 32'(bus.underrun_cnt), STATS ? 32'(exp_under) : 32'd0);
        chk({tag, ".overrun"}, 32'(bus.overrun), STATS ? 32'(exp_over) : 32'd0);
    endtask

    // One clock: push expected pixel, step, pop and compare, clear pulses.
    task automatic tick(input logic [7:0] addr);
        bus.vga_addr = addr;
        if (bus.flush || exp_show < 0) sb_q.push_back(BLANK);
        else                           sb_q.push_back(pix(exp_show, addr));
        @(posedge clk);
        #1;
        chk("vga_pixel", 32'(bus.vga_pixel), 32'(sb_q.pop_front()));
        bus.ppu_pix_valid = 1'b0;
        bus.ppu_line_done = 1'b0;
        bus.vga_line_end  = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic le_tick(input logic [7:0] addr);
        bus.vga_line_end = 1'b1;
        tick(addr);
    endtask

    task automatic done_tick(input logic [7:0] addr);
        bus.ppu_line_done = 1'b1;
        tick(addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(8'(i & 15));
    endtask

    task automatic write_line(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ppu_pix_valid = 1'b1;
            bus.ppu_pix_x     = 8'(i);
            bus.ppu_pix_data  = pix(id, 8'(i));
            tick(8'(i & 15));
        end
    endtask

    initial begin
        bus.ppu_pix_valid = 1'b0;
        bus.ppu_pix_x     = 8'd0;
        bus.ppu_pix_data  = 6'd0;
        bus.ppu_line_done = 1'b0;
        bus.flush         = 1'b0;
        bus.vga_addr      = 8'h40;
        bus.vga_line_end  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Step 1: reset state, idle line ends keep the output blank
        chk("reset.vga_pixel", 32'(bus.vga_pixel), 32'(BLANK));
        chk("reset.disp_valid", 32'(bus.disp_valid), 32'd0);
        chk_stats("reset");
        for (int i = 0; i < 5; i++) begin
            le_tick(8'h40);
            chk("idle.disp_valid", 32'(bus.disp_valid), 32'd0);
        end
        $display("step 1: reset/idle done, checks=%0d", checks);

        // Step 2: first full line A, shown at the next line end
        write_line(0, 256);
        done_tick(8'h40);
        chk("pending.disp_valid", 32'(bus.disp_valid), 32'd0);
        le_tick(8'h40);
        exp_show = 0;
        chk("first.disp_valid", 32'(bus.disp_valid), 32'd1);
        tick(8'h25);
        $display("step 2: line A displayed, checks=%0d", checks);

        // Step 3: B completes mid-line, A held for exactly 2 lines
        write_line(1, 16);
        done_tick(8'd3);
        idle(2);
        le_tick(8'd5);
        idle(3);
        le_tick(8'd6);
        exp_show = 1;
        idle(4);
        chk_stats("swapB");
        $display("step 3: line B after 2 repeats, checks=%0d", checks);

        // Step 4a: no new line before the swap point -> repeat B
        idle(3);
        le_tick(8'd1);
        idle(3);
        le_tick(8'd2);
        exp_under = 1;
        idle(2);
        chk_stats("underrun1");
        chk("underrun1.disp_valid", 32'(bus.disp_valid), 32'd1);
        $display("step 4a: single underrun, checks=%0d", checks);

        // Step 5: overrun while PENDING; dropped write must not corrupt C
        write_line(2, 16);
        done_tick(8'd0);
        bus.ppu_pix_valid = 1'b1;
        bus.ppu_pix_x     = 8'd3;
        bus.ppu_pix_data  = 6'h3F;
        done_tick(8'd1);
        exp_over = 1;
        chk_stats("overrun");
        le_tick(8'd2);
        le_tick(8'd3);
        exp_show = 2;
        tick(8'd3);
        idle(16);
        chk_stats("afterC");
        $display("step 5: overrun, line C intact, checks=%0d", checks);

        // Step 6a: line done coincident with the swap point
        write_line(3, 16);
        le_tick(8'd4);
        bus.ppu_line_done = 1'b1;
        le_tick(8'd5);
        exp_show = 3;
        idle(16);
        chk_stats("coincident");
        $display("step 6a: coincident swap, checks=%0d", checks);

        // Step 4b: 300 more underruns, counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            le_tick(8'(i & 15));
            le_tick(8'((i + 7) & 15));
            if (exp_under < 255) exp_under++;
            chk("sat.underrun_cnt", 32'(bus.underrun_cnt), STATS ? 32'(exp_under) : 32'd0);
        end
        chk_stats("saturated");
        $display("step 4b: underrun saturation, checks=%0d", checks);

        // Step 6b: flush mid-line blanks the very next pixel
        idle(2);
        bus.flush = 1'b1;
        tick(8'd9);
        exp_show = -1;
        chk("flush.disp_valid", 32'(bus.disp_valid), 32'd0);
        chk_stats("flush");
        idle(3);
        write_line(4, 16);
        done_tick(8'd2);
        le_tick(8'd3);
        exp_show = 4;
        chk("refill.disp_valid", 32'(bus.disp_valid), 32'd1);
        idle(16);
        $display("step 6b: flush and refill, checks=%0d", checks);

        // Asynchronous reset mid-line
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.vga_pixel", 32'(bus.vga_pixel), 32'(BLANK));
        chk("async_rst.disp_valid", 32'(bus.disp_valid), 32'd0);
        exp_under = 0;
        exp_over  = 0;
        chk_stats("async_rst");
        $display("step 7: async reset, checks=%0d", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
